// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator: register map and
// a parameter legality helper.
package baud_pkg;

  localparam logic [1:0] BAUD_ADDR_DIV_LO = 2'd0;
  localparam logic [1:0] BAUD_ADDR_DIV_HI = 2'd1;
  localparam logic [1:0] BAUD_ADDR_FRAC   = 2'd2;
  localparam logic [1:0] BAUD_ADDR_COMMIT = 2'd3;

  function automatic bit baud_params_ok(input int div_w, input int frac_w, input int osr);
    return (div_w >= 8) && (div_w <= 16) &&
           (frac_w >= 1) && (frac_w <= 8) &&
           (osr >= 2) && (osr <= 32);
  endfunction

endpackage

// File: rtl/baud_frac_gen_if.sv
// Byte-wide register write bus into the baud generator.
interface baud_frac_gen_if;
  logic       wrt;
  logic [1:0] addr;
  logic [7:0] data;

  modport master (output wrt, addr, data);
  modport slave  (input  wrt, addr, data);
endinterface

// File: rtl/baud_frac_div.sv
// Fractional receive divider: integer count plus a carry accumulator that
// stretches the next period by one cycle whenever the fraction overflows.
module baud_frac_div #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  act_div,
  input  logic [FRAC_W-1:0] act_frac,
  output logic              tick
);

  localparam logic [DIV_W:0] CNT_ONE = 1;

  logic [DIV_W:0]    rx_cntr_q, rx_cntr_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic              div_nz;

  assign div_nz = (act_div != '0);
  // One extra bit on the counter so div + extra never wraps.
  assign tick = enable && !rst && div_nz &&
                (rx_cntr_q == ({1'b0, act_div} + {{DIV_W{1'b0}}, extra_q}));

  always_comb begin
    rx_cntr_d = rx_cntr_q;
    acc_d     = acc_q;
    extra_d   = extra_q;
    if (enable) begin
      if (restart) begin
        rx_cntr_d = CNT_ONE;
        acc_d     = '0;
        extra_d   = 1'b0;
      end else if (tick) begin
        rx_cntr_d          = CNT_ONE;
        {extra_d, acc_d}   = {1'b0, acc_q} + {1'b0, act_frac};
      end else if (div_nz) begin
        rx_cntr_d = rx_cntr_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cntr_q <= CNT_ONE;
      acc_q     <= '0;
      extra_q   <= 1'b0;
    end else begin
      rx_cntr_q <= rx_cntr_d;
      acc_q     <= acc_d;
      extra_q   <= extra_d;
    end
  end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional-rate baud generator: shadowed divisor registers with atomic
// commit, oversampled rx tick and a phase-locked tx tick every OSR rx ticks.
module baud_frac_gen import baud_pkg::*; #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OSR    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  baud_frac_gen_if.slave   bus,
  input  logic             clr_tx_baud,
  output logic             rx_baud_en,
  output logic             tx_baud_en,
  output logic             cfg_active
);

  localparam bit               PARAMS_OK = baud_params_ok(DIV_W, FRAC_W, OSR);
  localparam int               OS_W      = $clog2(OSR);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]  OS_ONE    = 1;
  localparam logic [DIV_W-1:0] LO_MASK   = DIV_W'(16'h00FF);

  logic [DIV_W-1:0]  sh_div_q, sh_div_d, act_div_q, act_div_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d, act_frac_q, act_frac_d;
  logic [OS_W-1:0]   os_cntr_q, os_cntr_d;
  logic              wr_en, commit, restart;

  assign wr_en   = bus.wrt && enable;
  assign commit  = wr_en && (bus.addr == BAUD_ADDR_COMMIT);
  assign restart = commit || (enable && clr_tx_baud);

  always_comb begin
    sh_div_d   = sh_div_q;
    sh_frac_d  = sh_frac_q;
    act_div_d  = act_div_q;
    act_frac_d = act_frac_q;
    if (wr_en) begin
      case (bus.addr)
        BAUD_ADDR_DIV_LO: sh_div_d  = (sh_div_q & ~LO_MASK) | DIV_W'(bus.data);
        BAUD_ADDR_DIV_HI: sh_div_d  = (sh_div_q & LO_MASK) | DIV_W'({bus.data, 8'h00});
        BAUD_ADDR_FRAC:   sh_frac_d = bus.data[FRAC_W-1:0];
        default: begin
          act_div_d  = sh_div_q;
          act_frac_d = sh_frac_q;
        end
      endcase
    end
  end

  // Restart wins over the wrap, but a tick in the restart cycle is still emitted.
  always_comb begin
    os_cntr_d = os_cntr_q;
    if (restart)
      os_cntr_d = '0;
    else if (rx_baud_en)
      os_cntr_d = (os_cntr_q == OS_LAST) ? '0 : os_cntr_q + OS_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_div_q   <= '0;
      sh_frac_q  <= '0;
      act_div_q  <= '0;
      act_frac_q <= '0;
      os_cntr_q  <= '0;
    end else begin
      sh_div_q   <= sh_div_d;
      sh_frac_q  <= sh_frac_d;
      act_div_q  <= act_div_d;
      act_frac_q <= act_frac_d;
      os_cntr_q  <= os_cntr_d;
    end
  end

  baud_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .restart  (restart),
    .act_div  (act_div_q),
    .act_frac (act_frac_q),
    .tick     (rx_baud_en)
  );

  assign tx_baud_en = rx_baud_en && (os_cntr_q == OS_LAST);
  assign cfg_active = (act_div_q != '0);

  a_params_legal: assert property (@(posedge clk) PARAMS_OK);

endmodule
